reg_busy_scoreboard: RTL and testbench
======================================

Name: reg_busy_scoreboard

Overview:
- Parametrised successor to the single-cycle register-file write decoder: one-hot decodes destination and writeback register indices and tracks per-register "write pending" state for a multi-cycle/pipelined core.
- Sits between decode and the register file.
- Stalls issue on RAW/WAW hazards.
- Clears pending bits on writeback.
- Exports the one-hot write-enable vector to the register file.

Parameters:
- ADDR_W, 5, register index width; NREG = 2**ADDR_W registers.
- ZERO_HARDWIRED, 1, when 1 register 0 is never marked busy and never reports a hazard.
- WB_BYPASS, 1, when 1 a same-cycle writeback to a register suppresses that register's hazard.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ISSUE_VALID  input  1  decode presents an instruction.
- RD_EN  input  1  instruction writes a destination.
- ISSUE_RD  input  ADDR_W  destination index.
- RS1_EN  input  1  instruction reads rs1.
- RS1  input  ADDR_W  source 1 index.
- RS2_EN  input  1  instruction reads rs2.
- RS2  input  ADDR_W  source 2 index.
- ISSUE_READY  output  1  instruction may issue this cycle.
- WB_VALID  input  1  writeback occurring this cycle.
- WB_RD  input  ADDR_W  writeback index.
- FLUSH  input  1  synchronous clear of all pending state.
- WB_WE  output  NREG  one-hot register-file write enable (combinational).
- BUSY  output  NREG  registered pending-write vector.
- PENDING_CNT  output  ADDR_W+1  registered popcount of BUSY.
- WB_ERR  output  1  sticky flag: writeback to a non-busy register.

Behaviour:
- Reset (RST_N low, async): BUSY=0, PENDING_CNT=0, WB_ERR=0.
  - Combinational outputs follow their inputs with BUSY=0.
- Decoders: iss_dec = one-hot(ISSUE_RD) and wb_dec = one-hot(WB_RD), each a full NREG-wide decode.
  - Every index maps to exactly bit [index]; no aliasing across the upper half.
  - With ZERO_HARDWIRED=1, bit 0 of both decodes is forced 0.
- WB_WE = WB_VALID ? wb_dec : 0. Writeback to register 0 yields all-zero WB_WE when ZERO_HARDWIRED=1.
- Hazards (combinational, from current BUSY):
  - rs1_haz = RS1_EN & BUSY[RS1].
  - rs2_haz = RS2_EN & BUSY[RS2].
  - rd_haz (WAW) = RD_EN & BUSY[ISSUE_RD].
  - With WB_BYPASS=1, each term is masked when WB_VALID & WB_RD equals that index.
- ISSUE_READY = ~(rs1_haz | rs2_haz | rd_haz).
  - Independent of ISSUE_VALID.
  - Forced 0 while FLUSH=1.
- accept = ISSUE_VALID & ISSUE_READY & RD_EN.
- Next-state, in priority order:
  - FLUSH=1: BUSY<=0, PENDING_CNT<=0; issue and writeback are ignored for busy tracking. WB_WE still drives.
  - Otherwise: BUSY <= (BUSY & ~(WB_VALID ? wb_dec : 0)) | (accept ? iss_dec : 0).
  - Same-cycle writeback and accepted issue to the same index: bit ends set (new write pending).
- PENDING_CNT is updated in the same cycle as BUSY to popcount(next BUSY). It never exceeds NREG-ZERO_HARDWIRED.
- WB_ERR is set on WB_VALID & ~BUSY[WB_RD] with index ≠ 0 or ZERO_HARDWIRED=0.
  - Not set during FLUSH.
  - Cleared only by reset.
- Latency:
  - Issue marks busy visible on BUSY the next cycle.
  - A writeback clears it the next cycle; hazard release is same-cycle with WB_BYPASS=1, next cycle otherwise.
- Reset asserted mid-operation clears state immediately, regardless of CLK.

Test Plan:
- Reset, then issue RD=5 (RD_EN=1) → next cycle BUSY=0x00000020, PENDING_CNT=1. Then RS1=5, RS1_EN=1 → ISSUE_READY=0.
- BUSY[5] set, WB_VALID with WB_RD=5 and RS1=5 in the same cycle:
  - WB_BYPASS=1 → ISSUE_READY=1 and WB_WE=0x00000020.
  - Next cycle BUSY=0, PENDING_CNT=0.
- Sweep WB_RD 0..31 with WB_VALID=1 → WB_WE=1<<idx for idx 1..31, WB_WE=0 for idx 0. Index 16 must give 0x00010000.
- Issue RD=0 with ZERO_HARDWIRED=1 → BUSY stays 0 and ISSUE_READY remains 1.
- BUSY[7] set, same-cycle WB_RD=7 and accepted issue RD=7:
  - WB_BYPASS=1, so the WAW term on 7 is masked and the issue is accepted.
  - Next cycle BUSY[7]=1, PENDING_CNT unchanged.
- Issue 3 registers, then FLUSH=1 together with an issue of RD=9 → next cycle BUSY=0, PENDING_CNT=0.
  - Then WB_RD=9 → WB_ERR=1 and it stays 1.
  - Async RST_N low mid-cycle → WB_ERR=0 immediately.

Source files
------------

// File: rtl/reg_busy_scoreboard.sv
// Register busy scoreboard.
// Sits between decode and the register file. It one-hot decodes the issue
// destination and the writeback index, and keeps one "write pending" bit per
// architectural register. Issue is stalled on RAW hazards (rs1/rs2) and WAW
// hazards (rd) against pending writes. Pending bits are cleared on writeback.
// The decoded writeback vector is exported as the register-file write enable.
module reg_busy_scoreboard #(
  parameter int ADDR_W         = 5,
  parameter int ZERO_HARDWIRED = 1,
  parameter int WB_BYPASS      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     issue_rd,
  input  logic                  rs1_en,
  input  logic [ADDR_W-1:0]     rs1,
  input  logic                  rs2_en,
  input  logic [ADDR_W-1:0]     rs2,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic                  flush,
  output logic [(2**ADDR_W)-1:0] wb_we,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]       pending_cnt,
  output logic                  wb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam bit ZH   = (ZERO_HARDWIRED != 0);
  localparam bit BYP  = (WB_BYPASS != 0);

  // Full-width one-hot decode; each index owns exactly its own bit, so the
  // upper half of the index space never aliases onto the lower half.
  // Register 0 decodes to nothing when it is hardwired to zero.
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] v;
    v      = {NREG{1'b0}};
    v[idx] = 1'b1;
    if (ZH && (idx == {ADDR_W{1'b0}})) begin
      v = {NREG{1'b0}};
    end else begin
      v = v;
    end
    return v;
  endfunction

  // Number of set bits in a pending vector.
  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // True when the index names register 0 and that register is hardwired,
  // in which case it can never carry a hazard.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
    return ZH && (idx == {ADDR_W{1'b0}});
  endfunction

  logic [NREG-1:0]   busy_r;
  logic [ADDR_W:0]   cnt_r;
  logic              err_r;

  logic [NREG-1:0]   iss_dec_s;
  logic [NREG-1:0]   wb_dec_s;
  logic [NREG-1:0]   wb_clr_s;
  logic [NREG-1:0]   iss_set_s;
  logic              rs1_haz_s;
  logic              rs2_haz_s;
  logic              rd_haz_s;
  logic              ready_s;
  logic              accept_s;
  logic [NREG-1:0]   busy_nxt_s;
  logic [ADDR_W:0]   cnt_nxt_s;
  logic              err_nxt_s;

  // Decode both indices and build the writeback write-enable vector.
  always_comb begin
    iss_dec_s = onehot(issue_rd);
    wb_dec_s  = onehot(wb_rd);
    if (wb_valid) begin
      wb_clr_s = wb_dec_s;
    end else begin
      wb_clr_s = {NREG{1'b0}};
    end
  end

  // Hazard detection against the current pending vector. With bypass a
  // writeback to the same register this cycle releases the hazard at once,
  // since the value is arriving now.
  always_comb begin
    rs1_haz_s = rs1_en & busy_r[rs1] & ~is_zero_reg(rs1);
    rs2_haz_s = rs2_en & busy_r[rs2] & ~is_zero_reg(rs2);
    rd_haz_s  = rd_en  & busy_r[issue_rd] & ~is_zero_reg(issue_rd);
    if (BYP && wb_valid) begin
      if (wb_rd == rs1) begin
        rs1_haz_s = 1'b0;
      end else begin
        rs1_haz_s = rs1_haz_s;
      end
      if (wb_rd == rs2) begin
        rs2_haz_s = 1'b0;
      end else begin
        rs2_haz_s = rs2_haz_s;
      end
      if (wb_rd == issue_rd) begin
        rd_haz_s = 1'b0;
      end else begin
        rd_haz_s = rd_haz_s;
      end
    end else begin
      rs1_haz_s = rs1_haz_s;
      rs2_haz_s = rs2_haz_s;
      rd_haz_s  = rd_haz_s;
    end
  end

  // Issue handshake: ready does not depend on issue_valid, and a flush
  // blocks issue for the cycle it is asserted.
  always_comb begin
    if (flush) begin
      ready_s = 1'b0;
    end else begin
      ready_s = ~(rs1_haz_s | rs2_haz_s | rd_haz_s);
    end
    accept_s = issue_valid & ready_s & rd_en;
    if (accept_s) begin
      iss_set_s = iss_dec_s;
    end else begin
      iss_set_s = {NREG{1'b0}};
    end
  end

  // Next pending state. Set wins over clear so that a same-cycle writeback
  // and a new issue to one register leave the new write pending.
  always_comb begin
    busy_nxt_s = busy_r;
    err_nxt_s  = err_r;
    if (flush) begin
      busy_nxt_s = {NREG{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~wb_clr_s) | iss_set_s;
      if (wb_valid && !busy_r[wb_rd] && !is_zero_reg(wb_rd)) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end
    cnt_nxt_s = popcount(busy_nxt_s);
  end

  // State registers; reset clears everything immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREG{1'b0}};
      cnt_r  <= {(ADDR_W+1){1'b0}};
      err_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign issue_ready = ready_s;
  assign wb_we       = wb_clr_s;
  assign busy        = busy_r;
  assign pending_cnt = cnt_r;
  assign wb_err      = err_r;

endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Scoreboard bench for reg_busy_scoreboard: stimulus drives directed vectors
// and queues hand-computed expectations tagged with the cycle they apply to;
// a monitor compares them on the falling edge of that cycle.
module tb_reg_busy_scoreboard;

  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  localparam int K_READY = 0;
  localparam int K_WE    = 1;
  localparam int K_BUSY  = 2;
  localparam int K_CNT   = 3;
  localparam int K_ERR   = 4;

  logic              clk;
  logic              rst_n;
  logic              issue_valid;
  logic              rd_en;
  logic [ADDR_W-1:0] issue_rd;
  logic              rs1_en;
  logic [ADDR_W-1:0] rs1;
  logic              rs2_en;
  logic [ADDR_W-1:0] rs2;
  logic              issue_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic              flush;
  logic [NREG-1:0]   wb_we;
  logic [NREG-1:0]   busy;
  logic [ADDR_W:0]   pending_cnt;
  logic              wb_err;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   checks;
  int   errors;

  reg_busy_scoreboard #(.ADDR_W(ADDR_W), .ZERO_HARDWIRED(1), .WB_BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .rd_en(rd_en),
    .issue_rd(issue_rd), .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .wb_we(wb_we), .busy(busy), .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to align expectations with the cycle they belong to.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_now(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = v; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic expect_next(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = v; e.cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; rd_en = 1'b0; issue_rd = 5'd0;
    rs1_en = 1'b0; rs1 = 5'd0; rs2_en = 1'b0; rs2 = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] rd);
    issue_valid = 1'b1; rd_en = 1'b1; issue_rd = rd;
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].cyc == cyc) begin
        case (sb_q[i].kind)
          K_READY: act = {31'd0, issue_ready};
          K_WE:    act = wb_we;
          K_BUSY:  act = busy;
          K_CNT:   act = {26'd0, pending_cnt};
          K_ERR:   act = {31'd0, wb_err};
          default: act = 32'hxxxx_xxxx;
        endcase
        checks = checks + 1;
        if (act !== sb_q[i].exp) begin
          errors = errors + 1;
          $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h",
                   sb_q[i].name, cyc, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset state, then release reset.
    step();
    expect_now("rst_busy", K_BUSY, 32'h0);
    expect_now("rst_cnt", K_CNT, 32'd0);
    expect_now("rst_err", K_ERR, 32'd0);
    expect_now("rst_ready", K_READY, 32'd1);
    rst_n = 1'b1;

    // Issue rd=5.
    step();
    issue(5'd5);
    expect_now("iss5_ready", K_READY, 32'd1);
    expect_next("iss5_busy", K_BUSY, 32'h0000_0020);
    expect_next("iss5_cnt", K_CNT, 32'd1);

    // RAW on rs1=5.
    step();
    idle_inputs();
    rs1_en = 1'b1; rs1 = 5'd5;
    expect_now("raw5_ready", K_READY, 32'd0);

    // Writeback 5 with rs1=5 in the same cycle: bypass releases the hazard.
    step();
    wb_valid = 1'b1; wb_rd = 5'd5;
    expect_now("byp5_ready", K_READY, 32'd1);
    expect_now("byp5_we", K_WE, 32'h0000_0020);
    expect_next("wb5_busy", K_BUSY, 32'h0);
    expect_next("wb5_cnt", K_CNT, 32'd0);
    expect_next("wb5_err", K_ERR, 32'd0);

    // Writeback decode sweep under flush so no error is recorded.
    for (int idx = 0; idx < NREG; idx++) begin
      logic [31:0] one;
      step();
      idle_inputs();
      flush = 1'b1; wb_valid = 1'b1; wb_rd = idx[ADDR_W-1:0];
      one = 32'd1;
      expect_now($sformatf("we_sweep_%0d", idx), K_WE, (idx == 0) ? 32'd0 : (one << idx));
      if (idx == 0) begin
        expect_now("flush_ready", K_READY, 32'd0);
      end
      #1;
      if (idx == 16) begin
        checks = checks + 1;
        if (wb_we !== 32'h0001_0000) begin
          errors = errors + 1;
          $display("FAIL we_idx16_direct: got 0x%08h expected 0x00010000", wb_we);
        end
      end
    end
    expect_next("sweep_err", K_ERR, 32'd0);
    expect_next("sweep_busy", K_BUSY, 32'h0);

    // Issue rd=0: hardwired, never busy.
    step();
    idle_inputs();
    issue(5'd0);
    expect_now("iss0_ready", K_READY, 32'd1);
    expect_next("iss0_busy", K_BUSY, 32'h0);
    expect_next("iss0_cnt", K_CNT, 32'd0);

    // Issue rd=7.
    step();
    issue(5'd7);
    expect_next("iss7_busy", K_BUSY, 32'h0000_0080);

    // Same-cycle writeback 7 and issue 7: accepted, bit stays set.
    step();
    issue(5'd7); wb_valid = 1'b1; wb_rd = 5'd7;
    expect_now("waw7_byp_ready", K_READY, 32'd1);
    expect_now("waw7_byp_we", K_WE, 32'h0000_0080);
    expect_next("waw7_busy", K_BUSY, 32'h0000_0080);
    expect_next("waw7_cnt", K_CNT, 32'd1);
    expect_next("waw7_err", K_ERR, 32'd0);

    // WAW on 7 without writeback stalls.
    step();
    idle_inputs();
    issue(5'd7);
    expect_now("waw7_ready", K_READY, 32'd0);

    // RAW on rs2=7 stalls.
    step();
    idle_inputs();
    rs2_en = 1'b1; rs2 = 5'd7;
    expect_now("raw7_rs2_ready", K_READY, 32'd0);

    // Issue three more registers.
    step();
    idle_inputs();
    issue(5'd1);
    expect_next("iss1_busy", K_BUSY, 32'h0000_0082);
    expect_next("iss1_cnt", K_CNT, 32'd2);
    step();
    issue(5'd2);
    expect_next("iss2_busy", K_BUSY, 32'h0000_0086);
    expect_next("iss2_cnt", K_CNT, 32'd3);
    step();
    issue(5'd3);
    expect_next("iss3_busy", K_BUSY, 32'h0000_008E);
    expect_next("iss3_cnt", K_CNT, 32'd4);

    // Flush together with issue rd=9.
    step();
    issue(5'd9); flush = 1'b1;
    expect_now("flush9_ready", K_READY, 32'd0);
    expect_next("flush_busy", K_BUSY, 32'h0);
    expect_next("flush_cnt", K_CNT, 32'd0);
    expect_next("flush_err", K_ERR, 32'd0);

    // Writeback to non-busy register 9 sets the sticky error.
    step();
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd9;
    expect_now("wb9_we", K_WE, 32'h0000_0200);
    expect_next("wb9_err", K_ERR, 32'd1);

    step();
    idle_inputs();
    expect_next("err_sticky", K_ERR, 32'd1);

    // Asynchronous reset in the middle of the high phase.
    step();
    step();
    #1;
    rst_n = 1'b0;
    expect_now("async_rst_err", K_ERR, 32'd0);
    expect_now("async_rst_busy", K_BUSY, 32'h0);
    expect_now("async_rst_cnt", K_CNT, 32'd0);
    #1;
    checks = checks + 1;
    if (wb_err !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_rst_err_direct: got %b expected 0", wb_err);
    end
    checks = checks + 1;
    if (busy !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL async_rst_busy_direct: got 0x%08h expected 0x00000000", busy);
    end
    checks = checks + 1;
    if (pending_cnt !== 6'd0) begin
      errors = errors + 1;
      $display("FAIL async_rst_cnt_direct: got %0d expected 0", pending_cnt);
    end

    step();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    while (sb_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL unchecked_%s: expectation for cycle %0d never compared (now %0d)",
               sb_q[0].name, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
